run_monitor: RTL and testbench
==============================

# run_monitor

Run-completion monitor that sits downstream of the single-cycle `execution` CPU and consumes its PC and register-file write port. It detects program halt (PC parked on a self-jump), enforces a timeout, counts cycles and register writes, and shadows one watched register. It also raises pass/fail against an expected value. Benches use it in place of fixed-delay checks, and it is synthesizable for on-board self-test.

## Interface
Parameters:
- `HALT_CYCLES`, 4: consecutive cycles of unchanged PC that declare a halt (≥2).
- `TIMEOUT`, 50000: maximum cycles in RUN before the monitor gives up.
- `WATCH_REG`, 2: register index shadowed to `watch_value` (2 = $v0).

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: single-cycle pulse that begins a run; asserted after the CPU reset is released.
- `pc` in 32: CPU program counter.
- `reg_we` in 1: register-file write enable.
- `reg_waddr` in 5: register-file write address.
- `reg_wdata` in 32: register-file write data.
- `expected` in 32: expected final value of `WATCH_REG`; must be held stable.
- `hist_sel` in 2: history entry select (0 = most recent).
- `busy` out 1: high in RUN.
- `done` out 1: high in HALTED.
- `timeout` out 1: high in TIMEDOUT.
- `pass` out 1: `done && (watch_value == expected)`.
- `cycles` out 32: number of clock edges spent in RUN.
- `writes` out 32: count of non-$0 register writes during RUN.
- `watch_value` out 32: last value written to `WATCH_REG` during the run.
- `hist_addr` out 5, `hist_data` out 32: selected history entry.

## Operation
- States: IDLE, RUN, HALTED, TIMEDOUT. Reset forces IDLE and zeroes every output, counter, `prev_pc`, `stable_cnt` and the history.
- **IDLE**:
  - On `start`, go to RUN.
  - Clear `cycles`, `writes`, `watch_value`, `stable_cnt` and the history.
  - Load `prev_pc <= pc`.
- **RUN**, on each edge:
  - `cycles++`, saturating at 0xFFFFFFFF.
  - If `reg_we` and `reg_waddr != 0`: `writes++` (saturating).
    - If `reg_waddr == WATCH_REG`, also load `watch_value <= reg_wdata`.
  - Writes to $0 are ignored.
  - If `pc == prev_pc`, `stable_cnt++`; otherwise `stable_cnt <= 0`. Always `prev_pc <= pc`.
  - Halt: when `pc == prev_pc` and `stable_cnt == HALT_CYCLES-1`, go to HALTED.
  - Timeout: when `cycles == TIMEOUT-1` (the edge that makes `cycles == TIMEOUT`), go to TIMEDOUT.
  - If halt and timeout fire on the same edge, halt wins.
  - A register write on the transition edge is still counted and captured.
  - `start` in RUN is ignored.
- **HALTED / TIMEDOUT**:
  - Counters and `watch_value` are frozen; register writes are ignored.
  - `start` restarts a run, with the same clear and load as in IDLE.
- `pass` is combinational from registered state. It is 0 in every state except HALTED.

## Timing
- `busy` rises on the edge after `start` is sampled.
- If `pc` is constant from the first RUN cycle, HALTED is entered on the `HALT_CYCLES`-th RUN edge. At that point `cycles == HALT_CYCLES`.
- Any PC change resets the halt window. Halt therefore requires `HALT_CYCLES` consecutive equal samples.
- `done`, `timeout` and `busy` are registered, mutually exclusive, and change only on clock edges.
- Reset asserted mid-run returns the monitor to IDLE on that edge with all outputs 0.
- History outputs are combinational on `hist_sel`, with zero additional latency.

## Configuration
- `RUN_MON_HIST_EN` defined:
  - Adds a 4-entry ring buffer of `{reg_waddr, reg_wdata}`, written on every counted RUN write.
  - `hist_sel = 0` returns the newest entry, 3 the oldest.
  - Unwritten entries read as 0.
  - The buffer is cleared on reset and on `start`.
- `RUN_MON_HIST_EN` undefined:
  - No buffer is built; `hist_addr` and `hist_data` are tied to 0.
  - `hist_sel` is unused.

## Test plan
- Fib program loaded into the CPU, `expected = 32'h3a`, `start` pulsed after CPU reset → `done = 1`, `pass = 1`, `watch_value = 32'h3a`, `timeout = 0`.
- Stimulus-driven: `pc` increments by 4 for 10 cycles, then holds at 0x40 → HALTED exactly 4 edges after the hold begins; `cycles = 14` (10 increment edges + 4 hold edges).
- `TIMEOUT = 100`, `pc` always increments → TIMEDOUT with `cycles = 100`, `done = 0`, `pass = 0`.
- Writes: 3 to $0, 2 to $2 (5 then 7), 1 to $8 → `writes = 3`, `watch_value = 7`.
  - With `RUN_MON_HIST_EN`: `hist_sel = 0` gives ($8, data) and `hist_sel = 1` gives ($2, 7).
- Halt and timeout on the same edge (`TIMEOUT = HALT_CYCLES = 4`, `pc` constant) → HALTED. Then `reset` mid-run during a second `start` → IDLE, all outputs 0 on the next edge.

Source files
------------

// File: rtl/run_monitor.sv
// Run-completion monitor for the execution CPU: detects PC halt and timeout, and counts cycles and register writes.
// Optional write-history buffer is enabled by defining RUN_MON_HIST_EN.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for start; counters held clear, prev_pc tracks pc
// RUN      | counting cycles/writes, watching for halt or timeout
// HALTED   | pc parked for HALT_CYCLES samples; results frozen
// TIMEDOUT | TIMEOUT cycles elapsed without a halt; results frozen
module run_monitor #(
  parameter int HALT_CYCLES = 4,
  parameter int TIMEOUT     = 50000,
  parameter int WATCH_REG   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] pc,
  input  logic        reg_we,
  input  logic [4:0]  reg_waddr,
  input  logic [31:0] reg_wdata,
  input  logic [31:0] expected,
  input  logic [1:0]  hist_sel,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic        pass,
  output logic [31:0] cycles,
  output logic [31:0] writes,
  output logic [31:0] watch_value,
  output logic [4:0]  hist_addr,
  output logic [31:0] hist_data
);

  typedef enum logic [1:0] {IDLE, RUN, HALTED, TIMEDOUT} state_t;

  localparam logic [4:0]  WATCH_ADDR = 5'(WATCH_REG);
  localparam logic [31:0] HALT_LAST  = 32'(HALT_CYCLES - 1);
  localparam logic [31:0] TO_LAST    = 32'(TIMEOUT - 1);

  state_t      state;
  logic [31:0] prev_pc;
  logic [31:0] stable_cnt;
  logic        counted_write;
  logic        pc_same;
  logic        halt_hit;
  logic        timeout_hit;
  logic        restart;

  assign counted_write = reg_we && (reg_waddr != 5'd0);
  assign pc_same       = (pc == prev_pc);
  assign halt_hit      = pc_same && (stable_cnt == HALT_LAST);
  assign timeout_hit   = (cycles == TO_LAST);
  assign restart       = start && (state != RUN);

  assign pass = done && (watch_value == expected);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      cycles      <= '0;
      writes      <= '0;
      watch_value <= '0;
      prev_pc     <= '0;
      stable_cnt  <= '0;
    end else begin
      case (state)
        RUN: begin
          if (cycles != '1) cycles <= cycles + 32'd1;
          if (counted_write) begin
            if (writes != '1) writes <= writes + 32'd1;
            if (reg_waddr == WATCH_ADDR) watch_value <= reg_wdata;
          end
          stable_cnt <= pc_same ? stable_cnt + 32'd1 : '0;
          prev_pc    <= pc;
          // halt has priority when both fire on the same edge
          if (halt_hit) begin
            state <= HALTED;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (timeout_hit) begin
            state   <= TIMEDOUT;
            busy    <= 1'b0;
            timeout <= 1'b1;
          end
        end
        default: begin
          if (state == IDLE) begin
            cycles      <= '0;
            writes      <= '0;
            watch_value <= '0;
            stable_cnt  <= '0;
            prev_pc     <= pc;
          end
          if (start) begin
            state       <= RUN;
            busy        <= 1'b1;
            done        <= 1'b0;
            timeout     <= 1'b0;
            cycles      <= '0;
            writes      <= '0;
            watch_value <= '0;
            stable_cnt  <= '0;
            prev_pc     <= pc;
          end
        end
      endcase
    end
  end

`ifdef RUN_MON_HIST_EN
  // entry 0 is always the newest; entries shift toward 3 on each counted write
  logic [4:0]  h_addr [4];
  logic [31:0] h_data [4];

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      for (int i = 0; i < 4; i++) begin
        h_addr[i] <= '0;
        h_data[i] <= '0;
      end
    end else if (state == RUN && counted_write) begin
      h_addr[0] <= reg_waddr;
      h_data[0] <= reg_wdata;
      for (int i = 1; i < 4; i++) begin
        h_addr[i] <= h_addr[i-1];
        h_data[i] <= h_data[i-1];
      end
    end
  end

  assign hist_addr = h_addr[hist_sel];
  assign hist_data = h_data[hist_sel];
`else
  logic unused_hist;
  assign unused_hist = ^{hist_sel, restart};
  assign hist_addr   = '0;
  assign hist_data   = '0;
`endif

endmodule

// File: tb/tb_run_monitor.sv
// Scoreboard bench for run_monitor: three instances (default, TIMEOUT=100, TIMEOUT=HALT_CYCLES=4)
// share all inputs except start; a monitor per instance checks each run result as it completes.
module tb_run_monitor;

  typedef struct {
    string       name;
    logic        done;
    logic        tmo;
    logic        pass;
    logic [31:0] cycles;
    logic [31:0] writes;
    logic [31:0] watch;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, start_a, start_b, start_c;
  logic [31:0] pc, reg_wdata, expected;
  logic        reg_we;
  logic [4:0]  reg_waddr;
  logic [1:0]  hist_sel;

  logic        busy_a, done_a, tmo_a, pass_a;
  logic [31:0] cyc_a, wr_a, watch_a, hdata_a;
  logic [4:0]  haddr_a;
  logic        busy_b, done_b, tmo_b, pass_b;
  logic [31:0] cyc_b, wr_b, watch_b, hdata_b;
  logic [4:0]  haddr_b;
  logic        busy_c, done_c, tmo_c, pass_c;
  logic [31:0] cyc_c, wr_c, watch_c, hdata_c;
  logic [4:0]  haddr_c;

  exp_t q_a[$], q_b[$], q_c[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  run_monitor dut_a (
    .clk(clk), .reset(reset), .start(start_a), .pc(pc), .reg_we(reg_we), .reg_waddr(reg_waddr),
    .reg_wdata(reg_wdata), .expected(expected), .hist_sel(hist_sel), .busy(busy_a), .done(done_a),
    .timeout(tmo_a), .pass(pass_a), .cycles(cyc_a), .writes(wr_a), .watch_value(watch_a),
    .hist_addr(haddr_a), .hist_data(hdata_a));

  run_monitor #(.TIMEOUT(100)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .pc(pc), .reg_we(reg_we), .reg_waddr(reg_waddr),
    .reg_wdata(reg_wdata), .expected(expected), .hist_sel(hist_sel), .busy(busy_b), .done(done_b),
    .timeout(tmo_b), .pass(pass_b), .cycles(cyc_b), .writes(wr_b), .watch_value(watch_b),
    .hist_addr(haddr_b), .hist_data(hdata_b));

  run_monitor #(.TIMEOUT(4), .HALT_CYCLES(4)) dut_c (
    .clk(clk), .reset(reset), .start(start_c), .pc(pc), .reg_we(reg_we), .reg_waddr(reg_waddr),
    .reg_wdata(reg_wdata), .expected(expected), .hist_sel(hist_sel), .busy(busy_c), .done(done_c),
    .timeout(tmo_c), .pass(pass_c), .cycles(cyc_c), .writes(wr_c), .watch_value(watch_c),
    .hist_addr(haddr_c), .hist_data(hdata_c));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic cmp_rec(input exp_t e, input logic d, input logic t, input logic p, input logic b,
                         input logic [31:0] c, input logic [31:0] w, input logic [31:0] v);
    chk({e.name, ".done"},    32'(d), 32'(e.done));
    chk({e.name, ".timeout"}, 32'(t), 32'(e.tmo));
    chk({e.name, ".pass"},    32'(p), 32'(e.pass));
    chk({e.name, ".busy"},    32'(b), 32'd0);
    chk({e.name, ".cycles"},  c, e.cycles);
    chk({e.name, ".writes"},  w, e.writes);
    chk({e.name, ".watch"},   v, e.watch);
  endtask

  task automatic unexpected(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: run ended with no expected result queued", nm);
  endtask

  // Monitors: a run result is presented when done or timeout rises.
  initial begin
    logic prev = 1'b0;
    forever begin
      @(negedge clk);
      if ((done_a || tmo_a) && !prev) begin
        if (q_a.size() == 0) unexpected("dut_a");
        else cmp_rec(q_a.pop_front(), done_a, tmo_a, pass_a, busy_a, cyc_a, wr_a, watch_a);
      end
      prev = done_a || tmo_a;
    end
  end

  initial begin
    logic prev = 1'b0;
    forever begin
      @(negedge clk);
      if ((done_b || tmo_b) && !prev) begin
        if (q_b.size() == 0) unexpected("dut_b");
        else cmp_rec(q_b.pop_front(), done_b, tmo_b, pass_b, busy_b, cyc_b, wr_b, watch_b);
      end
      prev = done_b || tmo_b;
    end
  end

  initial begin
    logic prev = 1'b0;
    forever begin
      @(negedge clk);
      if ((done_c || tmo_c) && !prev) begin
        if (q_c.size() == 0) unexpected("dut_c");
        else cmp_rec(q_c.pop_front(), done_c, tmo_c, pass_c, busy_c, cyc_c, wr_c, watch_c);
      end
      prev = done_c || tmo_c;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic int qsize(input int which);
    if (which == 0) return q_a.size();
    if (which == 1) return q_b.size();
    return q_c.size();
  endfunction

  task automatic drain(input int which, input string nm, input int budget);
    for (int i = 0; i < budget && qsize(which) > 0; i++) cyc();
    if (qsize(which) > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: no run result within %0d cycles", nm, budget);
    end
  endtask

  task automatic push(input int which, input string nm, input logic d, input logic t, input logic p,
                      input logic [31:0] c, input logic [31:0] w, input logic [31:0] v);
    exp_t e;
    e.name = nm; e.done = d; e.tmo = t; e.pass = p; e.cycles = c; e.writes = w; e.watch = v;
    if (which == 0) q_a.push_back(e);
    else if (which == 1) q_b.push_back(e);
    else q_c.push_back(e);
  endtask

  task automatic chk_hist(input string nm, input logic [1:0] sel, input logic [4:0] ea, input logic [31:0] ed);
    hist_sel = sel;
    #1;
`ifdef RUN_MON_HIST_EN
    chk({nm, ".addr"}, 32'(haddr_a), 32'(ea));
    chk({nm, ".data"}, hdata_a, ed);
`else
    chk({nm, ".addr"}, 32'(haddr_a), 32'd0);
    chk({nm, ".data"}, hdata_a, 32'd0);
    if (ea == 5'd0 && ed == 32'd0) begin end
`endif
  endtask

  logic [4:0]  w_addr [6] = '{5'd0, 5'd0, 5'd0, 5'd2, 5'd2, 5'd8};
  logic [31:0] w_data [6] = '{32'd11, 32'd22, 32'd33, 32'd5, 32'd7, 32'h1234};
  logic [4:0]  f_addr [4] = '{5'd8, 5'd2, 5'd2, 5'd9};
  logic [31:0] f_data [4] = '{32'h15, 32'h22, 32'h3a, 32'h99};

  initial begin
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    pc = 32'h0; reg_we = 1'b0; reg_waddr = 5'd0; reg_wdata = 32'd0;
    expected = 32'h3a; hist_sel = 2'd0;
    repeat (3) cyc();
    chk("rst.busy", 32'(busy_a), 0); chk("rst.done", 32'(done_a), 0);
    chk("rst.timeout", 32'(tmo_a), 0); chk("rst.pass", 32'(pass_a), 0);
    chk("rst.cycles", cyc_a, 0); chk("rst.writes", wr_a, 0); chk("rst.watch", watch_a, 0);
    reset = 1'b0;
    cyc();

    // halt after 10 incrementing edges plus 4 hold edges at 0x40
    push(0, "halt14", 1'b1, 1'b0, 1'b0, 32'd14, 32'd0, 32'd0);
    start_a = 1'b1; pc = 32'h18; cyc(); start_a = 1'b0;
    chk("busy_after_start", 32'(busy_a), 1);
    for (int k = 1; k <= 10; k++) begin pc = 32'h18 + 32'(4 * k); cyc(); end
    for (int k = 0; k < 4; k++) begin pc = 32'h40; cyc(); end
    drain(0, "halt14", 5);
    reg_we = 1'b1; reg_waddr = 5'd2; reg_wdata = 32'hdead;
    for (int k = 0; k < 3; k++) begin pc = pc + 32'd4; cyc(); end
    reg_we = 1'b0;
    chk("frozen.cycles", cyc_a, 14); chk("frozen.writes", wr_a, 0); chk("frozen.watch", watch_a, 0);
    chk("frozen.done", 32'(done_a), 1);

    // write filtering: $0 ignored, watch follows $2, restart from HALTED
    expected = 32'd7;
    push(0, "writes", 1'b1, 1'b0, 1'b1, 32'd10, 32'd3, 32'd7);
    start_a = 1'b1; pc = 32'h100; cyc(); start_a = 1'b0;
    for (int k = 0; k < 6; k++) begin
      pc = 32'h100 + 32'(4 * (k + 1));
      reg_we = 1'b1; reg_waddr = w_addr[k]; reg_wdata = w_data[k];
      cyc();
    end
    reg_we = 1'b0;
    for (int k = 0; k < 4; k++) cyc();
    drain(0, "writes", 5);
    chk_hist("hist0", 2'd0, 5'd8, 32'h1234);
    chk_hist("hist1", 2'd1, 5'd2, 32'd7);
    chk_hist("hist2", 2'd2, 5'd2, 32'd5);
    chk_hist("hist3", 2'd3, 5'd0, 32'd0);

    // fib-style trace, constant pc, write on the halting edge still captured
    expected = 32'h3a;
    push(0, "fib", 1'b1, 1'b0, 1'b1, 32'd4, 32'd4, 32'h3a);
    start_a = 1'b1; pc = 32'h50; cyc(); start_a = 1'b0;
    for (int k = 0; k < 4; k++) begin
      reg_we = 1'b1; reg_waddr = f_addr[k]; reg_wdata = f_data[k];
      cyc();
    end
    reg_we = 1'b0;
    drain(0, "fib", 5);
    chk_hist("fib_hist0", 2'd0, 5'd9, 32'h99);
    chk_hist("fib_hist3", 2'd3, 5'd8, 32'h15);

    // timeout with pc always moving
    push(1, "timeout", 1'b0, 1'b1, 1'b0, 32'd100, 32'd0, 32'd0);
    start_b = 1'b1; pc = 32'h0; cyc(); start_b = 1'b0;
    for (int k = 1; k <= 150 && q_b.size() > 0; k++) begin pc = 32'(4 * k); cyc(); end
    if (q_b.size() > 0) begin n_checks++; n_fail++; $display("FAIL timeout: no run result within 150 cycles"); end

    // halt and timeout on the same edge: halt wins
    expected = 32'd0;
    push(2, "tie", 1'b1, 1'b0, 1'b1, 32'd4, 32'd0, 32'd0);
    start_c = 1'b1; pc = 32'h80; cyc(); start_c = 1'b0;
    for (int k = 0; k < 4; k++) cyc();
    drain(2, "tie", 5);

    // reset during a second run returns to IDLE with everything cleared
    start_c = 1'b1; cyc(); start_c = 1'b0;
    reg_we = 1'b1; reg_waddr = 5'd2; reg_wdata = 32'h55; pc = 32'h84; cyc();
    chk("rerun.busy", 32'(busy_c), 1);
    reset = 1'b1; cyc(); reg_we = 1'b0;
    chk("midrst.busy", 32'(busy_c), 0); chk("midrst.done", 32'(done_c), 0);
    chk("midrst.timeout", 32'(tmo_c), 0); chk("midrst.pass", 32'(pass_c), 0);
    chk("midrst.cycles", cyc_c, 0); chk("midrst.writes", wr_c, 0); chk("midrst.watch", watch_c, 0);
    chk("midrst.a_hist", hdata_a, 0);
    reset = 1'b0;
    repeat (3) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
